// File: rtl/pixel_write_sink.sv
// Pixel-write sink: buffers on-screen pixels in a FIFO and issues one acknowledged
// framebuffer write per pixel. Optional full-screen fill enabled by PIXEL_SINK_CLEAR_EN.
module pixel_write_sink #(
  parameter int FIFO_DEPTH = 8,
  parameter int X_MAX      = 160,
  parameter int Y_MAX      = 120
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  x,
  input  logic [6:0]  y,
  input  logic [2:0]  colour,
  input  logic        writeEn,
`ifdef PIXEL_SINK_CLEAR_EN
  input  logic        clear,
  input  logic [2:0]  clear_colour,
`endif
  output logic        ready,
  output logic [14:0] mem_addr,
  output logic [2:0]  mem_data,
  output logic        mem_we,
  input  logic        mem_ack,
  output logic        overflow,
  output logic [7:0]  drop_count,
  output logic        idle
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C   = CW'(FIFO_DEPTH);
  localparam logic [7:0]    X_LIM     = 8'(X_MAX);
  localparam logic [6:0]    Y_LIM     = 7'(Y_MAX);
  localparam logic [14:0]   ADDR_LAST = 15'd19199;

  typedef enum logic [1:0] {S_IDLE, S_WRITE, S_CLEAR} state_t;

  state_t        state_q;
  logic [17:0]   fifo_q [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q;
  logic [14:0]   mem_addr_q;
  logic [2:0]    mem_data_q;
  logic          mem_we_q;
  logic          overflow_q;
  logic [7:0]    drop_q;

  logic          on_screen_s, push_s, pop_s, clear_active_s, empty_s, idle_s, ready_s;
  logic [14:0]   addr_s;
  logic [17:0]   head_s;

  // y*160 + x without a multiplier
  assign addr_s = {1'b0, y, 7'd0} + {3'd0, y, 5'd0} + {7'd0, x};

  assign on_screen_s    = (x < X_LIM) && (y < Y_LIM);
  assign empty_s        = (count_q == '0);
  assign clear_active_s = (state_q == S_CLEAR);
  assign ready_s        = (count_q < DEPTH_C) && !clear_active_s;
  assign idle_s         = (state_q == S_IDLE) && empty_s && !clear_active_s;
  assign push_s         = writeEn && ready_s && on_screen_s;
  assign pop_s          = !empty_s &&
                          ((state_q == S_IDLE) || ((state_q == S_WRITE) && mem_ack));
  assign head_s         = fifo_q[rd_ptr_q];

  assign ready      = ready_s;
  assign idle       = idle_s;
  assign mem_addr   = mem_addr_q;
  assign mem_data   = mem_data_q;
  assign mem_we     = mem_we_q;
  assign overflow   = overflow_q;
  assign drop_count = drop_q;

  // FIFO storage (no reset needed; validity is tracked by count_q)
  always_ff @(posedge clk) begin
    if (push_s) begin
      fifo_q[wr_ptr_q] <= {addr_s, colour};
    end
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_s) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop_s)  rd_ptr_q <= rd_ptr_q + PW'(1);
      case ({push_s, pop_s})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Sticky overflow and saturating off-screen drop counter
  always_ff @(posedge clk) begin
    if (reset) begin
      overflow_q <= 1'b0;
      drop_q     <= 8'd0;
    end else begin
      if (writeEn && !ready_s) overflow_q <= 1'b1;
      if (writeEn && ready_s && !on_screen_s && (drop_q != 8'hFF)) drop_q <= drop_q + 8'd1;
    end
  end

  // Output FSM driving the framebuffer port
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      mem_we_q   <= 1'b0;
      mem_addr_q <= 15'd0;
      mem_data_q <= 3'd0;
    end else begin
      case (state_q)
        S_IDLE: begin
`ifdef PIXEL_SINK_CLEAR_EN
          if (clear && idle_s) begin
            state_q    <= S_CLEAR;
            mem_we_q   <= 1'b1;
            mem_addr_q <= 15'd0;
            mem_data_q <= clear_colour;
          end else
`endif
          if (pop_s) begin
            state_q    <= S_WRITE;
            mem_we_q   <= 1'b1;
            mem_addr_q <= head_s[17:3];
            mem_data_q <= head_s[2:0];
          end
        end
        S_WRITE: begin
          if (mem_ack) begin
            if (pop_s) begin
              mem_addr_q <= head_s[17:3];
              mem_data_q <= head_s[2:0];
            end else begin
              state_q  <= S_IDLE;
              mem_we_q <= 1'b0;
            end
          end
        end
`ifdef PIXEL_SINK_CLEAR_EN
        S_CLEAR: begin
          if (mem_ack) begin
            if (mem_addr_q == ADDR_LAST) begin
              state_q  <= S_IDLE;
              mem_we_q <= 1'b0;
            end else begin
              mem_addr_q <= mem_addr_q + 15'd1;
            end
          end
        end
`endif
        default: begin
          state_q  <= S_IDLE;
          mem_we_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pixel_write_sink.sv
// Directed self-checking bench for pixel_write_sink; clear fill is exercised
// only when PIXEL_SINK_CLEAR_EN is defined.
module tb_pixel_write_sink;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [7:0]  x = 8'd0;
  logic [6:0]  y = 7'd0;
  logic [2:0]  colour = 3'd0;
  logic        writeEn = 1'b0;
  logic        ready;
  logic [14:0] mem_addr;
  logic [2:0]  mem_data;
  logic        mem_we;
  logic        mem_ack = 1'b0;
  logic        overflow;
  logic [7:0]  drop_count;
  logic        idle;
`ifdef PIXEL_SINK_CLEAR_EN
  logic        clear = 1'b0;
  logic [2:0]  clear_colour = 3'd0;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pixel_write_sink dut (
    .clk(clk), .reset(reset), .x(x), .y(y), .colour(colour), .writeEn(writeEn),
`ifdef PIXEL_SINK_CLEAR_EN
    .clear(clear), .clear_colour(clear_colour),
`endif
    .ready(ready), .mem_addr(mem_addr), .mem_data(mem_data), .mem_we(mem_we),
    .mem_ack(mem_ack), .overflow(overflow), .drop_count(drop_count), .idle(idle)
  );

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1; tick(); tick(); reset = 1'b0;
    checks++;
    if ({ready, idle, mem_we, overflow} !== 4'b1100) begin
      errors++; $display("FAIL reset_flags got ready/idle/we/ovf=%b exp 1100", {ready, idle, mem_we, overflow});
    end
    checks++;
    if ({mem_addr, mem_data, drop_count} !== 26'd0) begin
      errors++; $display("FAIL reset_values got addr=%0d data=%0d drop=%0d exp 0", mem_addr, mem_data, drop_count);
    end
  endtask

  task automatic test_single();
    mem_ack = 1'b1;
    x = 8'd10; y = 7'd5; colour = 3'b101; writeEn = 1'b1;
    tick(); writeEn = 1'b0;
    checks++;
    if (mem_we !== 1'b0) begin errors++; $display("FAIL single_latency got we=%b exp 0", mem_we); end
    tick();
    checks++;
    if (mem_we !== 1'b1 || mem_addr !== 15'd810 || mem_data !== 3'd5) begin
      errors++; $display("FAIL single_write got we=%b addr=%0d data=%0d exp 1 810 5", mem_we, mem_addr, mem_data);
    end
    tick();
    checks++;
    if (mem_we !== 1'b0 || idle !== 1'b1) begin
      errors++; $display("FAIL single_done got we=%b idle=%b exp 0 1", mem_we, idle);
    end
  endtask

  task automatic test_burst();
    int bad_ready = 0;
    mem_ack = 1'b0;
    // one entry goes in flight, eight more fill the FIFO
    for (int i = 0; i < 9; i++) begin
      if (ready !== 1'b1) bad_ready++;
      x = 8'(i); y = 7'd1; colour = 3'(i); writeEn = 1'b1;
      tick();
    end
    writeEn = 1'b0;
    checks++;
    if (bad_ready != 0) begin errors++; $display("FAIL burst_ready_early got %0d not-ready cycles exp 0", bad_ready); end
    checks++;
    if (ready !== 1'b0 || overflow !== 1'b0) begin
      errors++; $display("FAIL burst_full got ready=%b ovf=%b exp 0 0", ready, overflow);
    end
    x = 8'd99; y = 7'd1; colour = 3'd7; writeEn = 1'b1;
    tick(); writeEn = 1'b0;
    checks++;
    if (overflow !== 1'b1) begin errors++; $display("FAIL burst_overflow got %b exp 1", overflow); end
    mem_ack = 1'b1;
    for (int k = 0; k < 9; k++) begin
      checks++;
      if (mem_we !== 1'b1 || mem_addr !== 15'(160 + k) || mem_data !== 3'(k)) begin
        errors++; $display("FAIL burst_write%0d got we=%b addr=%0d data=%0d exp 1 %0d %0d",
                          k, mem_we, mem_addr, mem_data, 160 + k, k);
      end
      tick();
    end
    checks++;
    if (mem_we !== 1'b0 || idle !== 1'b1 || overflow !== 1'b1) begin
      errors++; $display("FAIL burst_end got we=%b idle=%b ovf=%b exp 0 1 1", mem_we, idle, overflow);
    end
  endtask

  task automatic test_back_to_back();
    logic        we_s [8];
    logic [14:0] ad_s [8];
    logic [2:0]  da_s [8];
    mem_ack = 1'b1;
    for (int c = 0; c < 8; c++) begin
      we_s[c] = mem_we; ad_s[c] = mem_addr; da_s[c] = mem_data;
      writeEn = (c < 4);
      x = 8'(c * 3); y = 7'(100 + c); colour = 3'(c + 1);
      tick();
    end
    writeEn = 1'b0;
    for (int c = 0; c < 8; c++) begin
      logic exp_we;
      exp_we = (c >= 2) && (c <= 5);
      checks++;
      if (we_s[c] !== exp_we) begin
        errors++; $display("FAIL b2b_we%0d got %b exp %b", c, we_s[c], exp_we);
      end else if (exp_we) begin
        checks++;
        if (ad_s[c] !== 15'(16000 + 163 * (c - 2)) || da_s[c] !== 3'(c - 1)) begin
          errors++; $display("FAIL b2b_addr%0d got addr=%0d data=%0d exp %0d %0d",
                            c, ad_s[c], da_s[c], 16000 + 163 * (c - 2), c - 1);
        end
      end
    end
  endtask

  task automatic test_boundary();
    logic [7:0]  bx [4];
    logic [6:0]  by [4];
    int          writes = 0;
    logic [14:0] waddr = 15'd0;
    logic [2:0]  wdata = 3'd0;
    logic [7:0]  drop0;
    bx[0] = 8'd159; by[0] = 7'd119;
    bx[1] = 8'd160; by[1] = 7'd0;
    bx[2] = 8'd0;   by[2] = 7'd120;
    bx[3] = 8'd255; by[3] = 7'd127;
    drop0 = drop_count;
    mem_ack = 1'b1;
    for (int c = 0; c < 10; c++) begin
      if (mem_we === 1'b1) begin writes++; waddr = mem_addr; wdata = mem_data; end
      writeEn = (c < 4);
      if (c < 4) begin x = bx[c]; y = by[c]; colour = 3'd6; end
      tick();
    end
    writeEn = 1'b0;
    checks++;
    if (writes != 1 || waddr !== 15'd19199 || wdata !== 3'd6) begin
      errors++; $display("FAIL boundary_write got n=%0d addr=%0d data=%0d exp 1 19199 6", writes, waddr, wdata);
    end
    checks++;
    if (drop_count !== drop0 + 8'd3) begin
      errors++; $display("FAIL boundary_drop got %0d exp %0d", drop_count, drop0 + 8'd3);
    end
  endtask

  task automatic test_saturate();
    int writes = 0;
    x = 8'd200; y = 7'd10; writeEn = 1'b1;
    for (int i = 0; i < 300; i++) begin
      if (mem_we === 1'b1) writes++;
      tick();
    end
    writeEn = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (mem_we === 1'b1) writes++;
      tick();
    end
    checks++;
    if (drop_count !== 8'd255) begin errors++; $display("FAIL saturate_drop got %0d exp 255", drop_count); end
    checks++;
    if (writes != 0) begin errors++; $display("FAIL saturate_nowrite got %0d writes exp 0", writes); end
  endtask

  task automatic test_reset_mid();
    int writes = 0;
    mem_ack = 1'b0;
    for (int i = 0; i < 5; i++) begin
      x = 8'(20 + i); y = 7'd2; colour = 3'd3; writeEn = 1'b1;
      tick();
    end
    writeEn = 1'b0;
    checks++;
    if (mem_we !== 1'b1) begin errors++; $display("FAIL midreset_pre got we=%b exp 1", mem_we); end
    reset = 1'b1; tick(); reset = 1'b0;
    checks++;
    if ({mem_we, idle, ready, overflow} !== 4'b0110 || drop_count !== 8'd0) begin
      errors++; $display("FAIL midreset_state got we/idle/ready/ovf=%b drop=%0d exp 0110 0",
                        {mem_we, idle, ready, overflow}, drop_count);
    end
    mem_ack = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (mem_we === 1'b1) writes++;
      tick();
    end
    checks++;
    if (writes != 0 || idle !== 1'b1) begin
      errors++; $display("FAIL midreset_stale got %0d writes idle=%b exp 0 1", writes, idle);
    end
  endtask

`ifdef PIXEL_SINK_CLEAR_EN
  task automatic test_clear();
    int writes = 0;
    int bad = 0;
    mem_ack = 1'b1;
    clear_colour = 3'b010; clear = 1'b1;
    tick(); clear = 1'b0; clear_colour = 3'b111;
    for (int i = 0; i < 20000; i++) begin
      if (mem_we !== 1'b1) break;
      if (mem_addr !== 15'(writes) || mem_data !== 3'd2 || ready !== 1'b0 || idle !== 1'b0) bad++;
      writes++;
      tick();
    end
    checks++;
    if (writes != 19200 || bad != 0) begin
      errors++; $display("FAIL clear_fill got n=%0d bad=%0d exp 19200 0", writes, bad);
    end
    checks++;
    if (idle !== 1'b1 || ready !== 1'b1) begin
      errors++; $display("FAIL clear_end got idle=%b ready=%b exp 1 1", idle, ready);
    end
  endtask
`endif

  initial begin
    tick();
    test_reset();
    test_single();
    test_burst();
    test_back_to_back();
    test_boundary();
    test_saturate();
    test_reset_mid();
`ifdef PIXEL_SINK_CLEAR_EN
    test_clear();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
